// File: rtl/inst_encoder.sv
// inst_encoder: RV32I instruction encoder feeding a small output FIFO
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake
//   fmt, opcode, rd, rs1,  instruction format and fields
//   rs2, funct3, funct7,
//   imm                    signed immediate in byte units
//   out_valid/out_ready    output handshake
//   out_inst, out_err      queue head: encoded instruction and error flag
//   err_cnt                saturating count of erroneous entries pushed
// Optional: define INST_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit the format.
module inst_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]           r_inst [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_err;
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [7:0]            r_err_cnt;
  logic [31:0]           w_inst;
  logic                  w_err, w_fmt_bad, w_push, w_pop;

  always_comb begin
    w_inst = fmt == 3'd0 ? {imm[11:0], rs1, funct3, rd, opcode} :
             fmt == 3'd1 ? {imm[31:12], rd, opcode} :
             fmt == 3'd2 ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
             fmt == 3'd3 ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
             fmt == 3'd4 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
             fmt == 3'd5 ? {funct7, rs2, rs1, funct3, rd, opcode} : 32'd0;
    w_fmt_bad = fmt > 3'd5;
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  // An immediate fits N signed bits when all bits above bit N-2 equal the sign bit.
  logic w_range_bad;
  always_comb
    w_range_bad = (fmt == 3'd0 || fmt == 3'd4) ? !(&imm[31:11] || ~|imm[31:11]) :
                  fmt == 3'd3 ? !(&imm[31:12] || ~|imm[31:12]) || imm[0] :
                  fmt == 3'd2 ? !(&imm[31:20] || ~|imm[31:20]) || imm[0] :
                  fmt == 3'd1 ? |imm[11:0] : 1'b0;
  assign w_err = w_fmt_bad | w_range_bad;
`else
  assign w_err = w_fmt_bad;
`endif

  assign in_ready  = r_count < CW'(FIFO_DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Head is gated so reset forces the outputs to zero without clearing storage.
  assign out_inst  = out_valid ? r_inst[r_rptr] : 32'd0;
  assign out_err   = out_valid & r_err[r_rptr];
  assign err_cnt   = r_err_cnt;

  always_ff @(posedge clk)
    if (w_push) begin
      r_inst[r_wptr] <= w_inst;
      r_err[r_wptr]  <= w_err;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr == PW'(FIFO_DEPTH - 1) ? '0 : r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr == PW'(FIFO_DEPTH - 1) ? '0 : r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push && w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scoreboard bench for inst_encoder
module tb_inst_encoder;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_err;
  logic [2:0]  fmt = '0, funct3 = '0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0, out_inst;
  logic [7:0]  err_cnt;
  int          total = 0, bad = 0, err_exp = 0;
  logic [32:0] q[$];
  logic [32:0] m;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] enc(input logic [2:0] f, input logic [6:0] op,
                                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] i;
    logic        e;
    int          v;
    e = 1'b0;
    v = im;
    case (f)
      3'd0: i = {im[11:0], s1, f3, d, op};
      3'd1: i = {im[31:12], d, op};
      3'd2: i = {im[20], im[10:1], im[11], im[19:12], d, op};
      3'd3: i = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
      3'd4: i = {im[11:5], s2, s1, f3, im[4:0], op};
      3'd5: i = {f7, s2, s1, f3, d, op};
      default: begin i = 32'd0; e = 1'b1; end
    endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
    case (f)
      3'd0, 3'd4: e = v < -2048 || v > 2047;
      3'd3: e = v < -4096 || v > 4095 || im[0];
      3'd2: e = v < -1048576 || v > 1048575 || im[0];
      3'd1: e = im[11:0] != 12'd0;
      default: ;
    endcase
`endif
    return {e, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic note_push();
    logic [32:0] e;
    e = enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
    q.push_back(e);
    if (e[32] && err_exp < 255) err_exp++;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im);
    drive(f, op, d, s1, s2, f3, f7, im);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    note_push();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [32:0] e;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL %s_queue got=empty exp=entry", tag);
    end
    e = q.size() != 0 ? q.pop_front() : 33'd0;
    chk({tag, "_inst"}, out_inst, e[31:0]);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e[32]});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("i_latency", {31'd0, out_valid}, 32'd1);
    chk("i_const", out_inst, 32'h00500093);
    pop_check("i");
    send(3'd2, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    send(3'd4, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("j_hold", out_inst, 32'h008000EF);
    end
    pop_check("j");
    chk("s_const", out_inst, 32'h0020A223);
    pop_check("s");
    send(3'd5, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
    send(3'd1, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFFFFF8);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("third_blocked", {31'd0, in_ready}, 32'd0);
    end
    pop_check("r");
    chk("third_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    note_push();
    @(negedge clk);
    in_valid = 1'b0;
    pop_check("u");
    pop_check("b");
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    send(3'd0, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    drive(3'd4, 7'h23, 5'd0, 5'd5, 5'd6, 3'd0, 7'd0, 32'hFFFFF800);
    in_valid = 1'b1;
    out_ready = 1'b1;
    m = q.pop_front();
    chk("pp_head", out_inst, m[31:0]);
    @(posedge clk);
    note_push();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pp_count", {31'd0, out_valid}, 32'd1);
    pop_check("pp");
    chk("pp_empty", {31'd0, out_valid}, 32'd0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd1);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    chk("b_odd_err", {31'd0, out_err}, 32'd1);
    chk("b_odd_cnt", {24'd0, err_cnt}, 32'd1);
`else
    chk("b_odd_err", {31'd0, out_err}, 32'd0);
    chk("b_odd_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    pop_check("b_odd");
    send(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd1);
    chk("f7_inst", out_inst, 32'd0);
    chk("f7_err", {31'd0, out_err}, 32'd1);
    pop_check("f7");
    chk("f7_cnt", {24'd0, err_cnt}, err_exp);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    q.delete();
    chk("sat_cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat_model", {24'd0, err_cnt}, err_exp);
    chk("sat_empty", {31'd0, out_valid}, 32'd0);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_errcnt", {24'd0, err_cnt}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_inst", out_inst, 32'd0);
    q.delete();
    err_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    send(3'd0, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFB);
    chk("post_rst_latency", {31'd0, out_valid}, 32'd1);
    pop_check("post_rst");
    chk("post_rst_cnt", {24'd0, err_cnt}, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
